// File: rtl/sdbuf_pkg.sv
// Shared requester IDs, defaults and the read-return tag for the sector-buffer arbiter.
package sdbuf_pkg;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_e;

  localparam int MAX_BURST_DEFAULT = 16;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_R0) ? REQ_R1 : REQ_R0;
  endfunction

endpackage

// File: rtl/sdbuf_port_arbiter_if.sv
// Requester handshakes plus the RAM port A bundle seen by the arbiter.
interface sdbuf_port_arbiter_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 9
);

  logic                 r0_req;
  logic                 r0_we;
  logic [ADDRWIDTH-1:0] r0_addr;
  logic [DATAWIDTH-1:0] r0_wdata;
  logic                 r0_lock;
  logic                 r0_ack;
  logic                 r0_rvalid;
  logic [DATAWIDTH-1:0] r0_rdata;

  logic                 r1_req;
  logic                 r1_we;
  logic [ADDRWIDTH-1:0] r1_addr;
  logic [DATAWIDTH-1:0] r1_wdata;
  logic                 r1_lock;
  logic                 r1_ack;
  logic                 r1_rvalid;
  logic [DATAWIDTH-1:0] r1_rdata;

  logic [ADDRWIDTH-1:0] ram_address;
  logic [DATAWIDTH-1:0] ram_data;
  logic                 ram_wren;
  logic [DATAWIDTH-1:0] ram_q;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    output r0_ack, r0_rvalid, r0_rdata,
    output r1_ack, r1_rvalid, r1_rdata,
    output ram_address, ram_data, ram_wren,
    input  ram_q
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    input  r0_ack, r0_rvalid, r0_rdata,
    input  r1_ack, r1_rvalid, r1_rdata,
    input  ram_address, ram_data, ram_wren,
    output ram_q
  );

endinterface

// File: rtl/sdbuf_rr_pick.sv
// Combinational grant pick: single requester wins outright, otherwise lock-with-burst-cap
// keeps the last winner, and plain contention alternates.
module sdbuf_rr_pick
  import sdbuf_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  logic    lock0,
  input  logic    lock1,
  input  req_id_e last_id,
  input  logic    burst_full,
  output logic    gnt0,
  output logic    gnt1
);

  logic    last_lock_s;
  req_id_e pick_s;

  // grant selection
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    last_lock_s = (last_id == REQ_R0) ? lock0 : lock1;
    pick_s      = other_req(last_id);
    case ({req1, req0})
      2'b01: gnt0 = 1'b1;
      2'b10: gnt1 = 1'b1;
      2'b11: begin
        if (last_lock_s && !burst_full) begin
          pick_s = last_id;
        end else begin
          pick_s = other_req(last_id);
        end
        gnt0 = (pick_s == REQ_R0);
        gnt1 = (pick_s == REQ_R1);
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sdbuf_port_arbiter.sv
// Two-requester arbiter onto RAM port A: registered RAM drive, two-stage read-return
// pipeline and lock bursts capped at MAX_BURST while the other side waits.
module sdbuf_port_arbiter
  import sdbuf_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 9,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input logic                 clock,
  input logic                 reset,
  sdbuf_port_arbiter_if.slave bus
);

  localparam int              CNTW      = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] BURST_MAX = CNTW'(MAX_BURST);
  localparam logic [CNTW-1:0] BURST_ONE = CNTW'(1);

  req_id_e              last_q, last_d;
  logic [CNTW-1:0]      burst_q, burst_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 wren_q, wren_d;
  rd_tag_t              rd_tag_q, rd_tag_d;
  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;

  logic    gnt0_s, gnt1_s, ack0_s, ack1_s, burst_full_s, sel_we_s;
  req_id_e acc_id_s;

  assign burst_full_s = (burst_q == BURST_MAX);

  sdbuf_rr_pick u_pick (
    .req0       (bus.r0_req),
    .req1       (bus.r1_req),
    .lock0      (bus.r0_lock),
    .lock1      (bus.r1_lock),
    .last_id    (last_q),
    .burst_full (burst_full_s),
    .gnt0       (gnt0_s),
    .gnt1       (gnt1_s)
  );

  // reset gates the grant so no transfer can slip through a reset edge
  assign ack0_s = gnt0_s & ~reset;
  assign ack1_s = gnt1_s & ~reset;

  assign bus.r0_ack      = ack0_s;
  assign bus.r1_ack      = ack1_s;
  assign bus.r0_rvalid   = rvalid0_q;
  assign bus.r1_rvalid   = rvalid1_q;
  assign bus.r0_rdata    = bus.ram_q;
  assign bus.r1_rdata    = bus.ram_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  assign bus.ram_wren    = wren_q;

  // next-state: capture the accepted request and advance the burst counter
  always_comb begin
    last_d    = last_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    rd_tag_d  = '{valid: 1'b0, id: REQ_R0};
    acc_id_s  = ack1_s ? REQ_R1 : REQ_R0;
    sel_we_s  = ack1_s ? bus.r1_we : bus.r0_we;
    if (ack0_s || ack1_s) begin
      last_d = acc_id_s;
      if (acc_id_s != last_q) begin
        burst_d = BURST_ONE;
      end else if (!burst_full_s) begin
        burst_d = burst_q + BURST_ONE;
      end else begin
        burst_d = burst_q;
      end
      addr_d   = ack1_s ? bus.r1_addr : bus.r0_addr;
      data_d   = ack1_s ? bus.r1_wdata : bus.r0_wdata;
      wren_d   = sel_we_s;
      rd_tag_d = '{valid: ~sel_we_s, id: acc_id_s};
    end else begin
      wren_d = 1'b0;
    end
    // second stage lines up with the RAM's registered q
    rvalid0_d = rd_tag_q.valid && (rd_tag_q.id == REQ_R0);
    rvalid1_d = rd_tag_q.valid && (rd_tag_q.id == REQ_R1);
  end

  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q    <= REQ_R1;
      burst_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      rd_tag_q  <= '{valid: 1'b0, id: REQ_R0};
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      burst_q   <= burst_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      rd_tag_q  <= rd_tag_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

endmodule

// File: tb/tb_sdbuf_port_arbiter.sv
// Bench: behavioural RAM, arbitration model built from the grant rules, per-scenario checks.
module tb_sdbuf_port_arbiter;
  import sdbuf_pkg::*;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int MB = MAX_BURST_DEFAULT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sdbuf_port_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  sdbuf_port_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .MAX_BURST(MB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // single-port view of the dual-port RAM, 1-cycle registered read
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.ram_wren) ram_mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= ram_mem[bus.ram_address];
  end

  // reference model state
  int            m_last  = 1;
  int            m_burst = 0;
  logic          m_wren  = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            known  [0:(1<<AW)-1];
  typedef struct { int due; int id; logic [DW-1:0] data; bit ok; } rd_exp_t;
  rd_exp_t rdq[$];

  function automatic logic [1:0] model_pick();
    bit last_lock;
    if (reset) return 2'b00;
    if (!bus.r0_req && !bus.r1_req) return 2'b00;
    if (bus.r0_req && !bus.r1_req) return 2'b01;
    if (!bus.r0_req && bus.r1_req) return 2'b10;
    last_lock = (m_last == 0) ? bus.r0_lock : bus.r1_lock;
    if (last_lock && m_burst < MB) return (m_last == 0) ? 2'b01 : 2'b10;
    return (m_last == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_commit(output int g);
    logic [1:0] p;
    p = model_pick();
    g = -1;
    if (reset) begin
      m_last = 1; m_burst = 0; m_wren = 1'b0; m_addr = '0; m_data = '0;
      rdq.delete();
      return;
    end
    m_wren = 1'b0;
    if (p == 2'b00) return;
    g       = p[1] ? 1 : 0;
    m_burst = (g == m_last) ? ((m_burst < MB) ? m_burst + 1 : MB) : 1;
    m_last  = g;
    m_addr  = (g == 1) ? bus.r1_addr : bus.r0_addr;
    m_data  = (g == 1) ? bus.r1_wdata : bus.r0_wdata;
    m_wren  = (g == 1) ? bus.r1_we : bus.r0_we;
    if (m_wren) begin
      shadow[m_addr] = m_data;
      known[m_addr]  = 1'b1;
    end else begin
      rdq.push_back('{due: cyc + 2, id: g, data: shadow[m_addr], ok: known[m_addr]});
    end
  endtask

  task automatic drive(input bit q0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit l0, input bit q1, input bit w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input bit l1);
    bus.r0_req = q0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_wdata = d0; bus.r0_lock = l0;
    bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1; bus.r1_lock = l1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // waits to the falling edge and gathers observed vs model values
  task automatic sample(output logic [21:0] o, output logic [21:0] e, output logic [DW-1:0] rd,
                        output logic [DW-1:0] rde, output bit rdc);
    logic [1:0] rv;
    @(negedge clock);
    rv = 2'b00; rdc = 1'b0; rde = '0; rd = bus.r0_rdata;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      rv[rdq[0].id] = 1'b1;
      rde = rdq[0].data;
      rdc = rdq[0].ok;
      rd  = (rdq[0].id == 1) ? bus.r1_rdata : bus.r0_rdata;
      void'(rdq.pop_front());
    end
    o = {bus.ram_data, bus.ram_address, bus.ram_wren, bus.r1_rvalid, bus.r0_rvalid,
         bus.r1_ack, bus.r0_ack};
    e = {m_data, m_addr, m_wren, rv, model_pick()};
  endtask

  task automatic test_reset();
    logic [21:0] o, e; logic [DW-1:0] rd, rde; bit rdc; int g;
    reset = 1'b1;
    drive(1'b1, 1'b1, 9'h001, 8'h11, 1'b0, 1'b1, 1'b1, 9'h002, 8'h22, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      sample(o, e, rd, rde, rdc);
      total++;
      if (o !== e) begin bad++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, o, e); end
      model_commit(g);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    drive_idle();
  endtask

  task automatic test_write_read();
    logic [21:0] o, e; logic [DW-1:0] rd, rde; bit rdc; int g;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 9'h010, 8'hA5, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        1:       drive(1'b1, 1'b0, 9'h010, 8'h00, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        default: drive_idle();
      endcase
      sample(o, e, rd, rde, rdc);
      total++;
      if (o !== e) begin bad++; $display("FAIL wr_rd cyc=%0d got=%h want=%h", cyc, o, e); end
      if (rdc) begin
        total++;
        if (rd !== rde) begin bad++; $display("FAIL wr_rd_data got=%h want=%h", rd, rde); end
      end
      if (i == 1) begin
        total++;
        if (bus.ram_wren !== 1'b1 || bus.ram_address !== 9'h010)
          begin bad++; $display("FAIL wr_pulse wren=%b addr=%h want 1/010", bus.ram_wren, bus.ram_address); end
      end
      if (i == 3) begin
        total++;
        if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 8'hA5)
          begin bad++; $display("FAIL rd_return rvalid=%b rdata=%h want 1/a5", bus.r0_rvalid, bus.r0_rdata); end
      end
      model_commit(g);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_alternate();
    logic [21:0] o, e; logic [DW-1:0] rd, rde; bit rdc; int g; int prev = -1; int cur;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 9'h020, 8'h00, 1'b0, 1'b1, 1'b0, 9'h021, 8'h00, 1'b0);
      sample(o, e, rd, rde, rdc);
      total++;
      if (o !== e) begin bad++; $display("FAIL alternate cyc=%0d got=%h want=%h", cyc, o, e); end
      cur = bus.r1_ack ? 1 : 0;
      total++;
      if ((bus.r0_ack ^ bus.r1_ack) !== 1'b1 || cur == prev)
        begin bad++; $display("FAIL alt_order acks=%b%b prev=%0d", bus.r1_ack, bus.r0_ack, prev); end
      prev = cur;
      model_commit(g);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lock_burst();
    logic [21:0] o, e; logic [DW-1:0] rd, rde; bit rdc; int g; int n1 = 0; int seq[$];
    drive(1'b1, 1'b0, 9'h030, 8'h00, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    sample(o, e, rd, rde, rdc);
    total++;
    if (o !== e) begin bad++; $display("FAIL burst_pre cyc=%0d got=%h want=%h", cyc, o, e); end
    model_commit(g);
    @(posedge clock); #1;
    for (int i = 0; i < 100 && n1 < 40; i++) begin
      drive(1'b1, 1'b0, 9'h030, 8'h00, 1'b0, 1'b1, 1'b0, AW'(9'h100 + n1), 8'h00, 1'b1);
      sample(o, e, rd, rde, rdc);
      total++;
      if (o !== e) begin bad++; $display("FAIL burst cyc=%0d got=%h want=%h", cyc, o, e); end
      if (rdc) begin
        total++;
        if (rd !== rde) begin bad++; $display("FAIL burst_data got=%h want=%h", rd, rde); end
      end
      if (bus.r1_ack) seq.push_back(1);
      else if (bus.r0_ack) seq.push_back(0);
      model_commit(g);
      if (g == 1) n1++;
      @(posedge clock); #1;
    end
    total++;
    if (n1 != 40) begin bad++; $display("FAIL burst_budget r1_reads=%0d want=40", n1); end
    for (int k = 0; k < 18; k++) begin
      total++;
      if (k >= seq.size() || seq[k] != ((k == 16) ? 0 : 1))
        begin bad++; $display("FAIL burst_seq idx=%0d got=%0d want=%0d", k, (k < seq.size()) ? seq[k] : -1, (k == 16) ? 0 : 1); end
    end
  endtask

  task automatic test_reset_drop();
    logic [21:0] o, e; logic [DW-1:0] rd, rde; bit rdc; int g;
    for (int i = 0; i < 5; i++) begin
      reset = (i == 1);
      case (i)
        0:       drive(1'b1, 1'b0, 9'h030, 8'h00, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        2:       drive(1'b1, 1'b0, 9'h031, 8'h00, 1'b0, 1'b1, 1'b0, 9'h032, 8'h00, 1'b0);
        default: drive_idle();
      endcase
      sample(o, e, rd, rde, rdc);
      total++;
      if (o !== e) begin bad++; $display("FAIL rst_drop cyc=%0d got=%h want=%h", cyc, o, e); end
      if (i >= 2 && i <= 3) begin
        total++;
        if (bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0 || bus.ram_wren !== 1'b0)
          begin bad++; $display("FAIL rst_no_rvalid rv=%b%b wren=%b want 0", bus.r1_rvalid, bus.r0_rvalid, bus.ram_wren); end
      end
      if (i == 2) begin
        total++;
        if ({bus.r1_ack, bus.r0_ack} !== 2'b01)
          begin bad++; $display("FAIL rst_first_grant got=%b%b want=01", bus.r1_ack, bus.r0_ack); end
      end
      model_commit(g);
      @(posedge clock); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_raw();
    logic [21:0] o, e; logic [DW-1:0] rd, rde; bit rdc; int g;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 9'h1FF, 8'h3C, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        1:       drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 9'h1FF, 8'h00, 1'b0);
        default: drive_idle();
      endcase
      sample(o, e, rd, rde, rdc);
      total++;
      if (o !== e) begin bad++; $display("FAIL raw cyc=%0d got=%h want=%h", cyc, o, e); end
      if (i == 3) begin
        total++;
        if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 8'h3C)
          begin bad++; $display("FAIL raw_data rvalid=%b rdata=%h want 1/3c", bus.r1_rvalid, bus.r1_rdata); end
      end
      model_commit(g);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    logic [21:0] o, e; logic [DW-1:0] rd, rde; bit rdc; int g;
    bit pend[2]; bit pw[2]; bit pl[2]; logic [AW-1:0] pa[2]; logic [DW-1:0] pd[2];
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 403; i++) begin
      reset = (i < 400) && ($urandom_range(0, 49) == 0);
      for (int n = 0; n < 2; n++) begin
        if (i >= 400) pend[n] = 1'b0;
        else if (!pend[n] && $urandom_range(0, 2) != 0) begin
          pend[n] = 1'b1;
          pw[n]   = 1'($urandom_range(0, 1));
          pl[n]   = ($urandom_range(0, 3) != 0);
          pa[n]   = AW'($urandom_range(0, 15));
          pd[n]   = DW'($urandom);
        end
      end
      drive(pend[0], pw[0], pa[0], pd[0], pl[0], pend[1], pw[1], pa[1], pd[1], pl[1]);
      sample(o, e, rd, rde, rdc);
      total++;
      if (o !== e) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, o, e); end
      if (rdc) begin
        total++;
        if (rd !== rde) begin bad++; $display("FAIL random_data cyc=%0d got=%h want=%h", cyc, rd, rde); end
      end
      model_commit(g);
      if (g >= 0) pend[g] = 1'b0;
      @(posedge clock); #1;
    end
    reset = 1'b0;
    total++;
    if (rdq.size() != 0) begin bad++; $display("FAIL random_drain left=%0d want=0", rdq.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_lock_burst();
    test_reset_drop();
    test_raw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
